// File: rtl/abro_stim_gen.sv
// abro_stim_gen
//   Pattern transmitter for the ABRO detector path. Symbols (A,B) are loaded
//   into a buffer while idle, then replayed on registered A/B outputs, each
//   symbol held for hold_cycles+1 cycles, optionally looping. A built-in copy
//   of the detector tracks the emitted stream and reports expect_O plus a
//   saturating count of detections.
//
// Ports
//   clk, reset_n          clock, async active-low reset
//   clear                 empty buffer, zero match_count (idle only)
//   load_valid/load_sym   push a symbol ({A,B}) into the buffer
//   load_ready            buffer accepts a symbol (idle and not full)
//   start/stop            begin a run (idle) / abort a run (running)
//   loop, hold_cycles     run options, captured at start
//   A, B                  stimulus outputs
//   busy, done            running flag / one-cycle end-of-run pulse
//   expect_O, match_count detector model output / detections since start/clear
module abro_stim_gen #(
  parameter int MAX_LEN = 16,
  parameter int HOLD_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              load_valid,
  input  logic [1:0]        load_sym,
  output logic              load_ready,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic              A,
  output logic              B,
  output logic              busy,
  output logic              done,
  output logic              expect_O,
  output logic [15:0]       match_count
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LW-1:0] FULL = LW'(MAX_LEN);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {M0, M1, M2, M3} mstate_t;

  state_t                  state, state_nx;
  mstate_t                 mstate, mstate_nx;
  logic [MAX_LEN-1:0][1:0] sym_buf;
  logic [LW-1:0]           length, length_nx, run_len, run_len_nx, len_after;
  logic [IW-1:0]           idx, idx_nx;
  logic [HOLD_W-1:0]       hcnt, hcnt_nx, hold_q, hold_nx;
  logic                    loop_q, loop_nx;
  logic [1:0]              ab, ab_nx, sym0;
  logic                    done_nx, wr_en, last, match_clr;

  assign load_ready = (state == IDLE) && (length < FULL);
  // clear beats a same-cycle load
  assign wr_en      = load_ready && load_valid && !clear;
  assign len_after  = clear ? '0 : length + LW'(wr_en);
  // a symbol written in the start cycle into an empty buffer is symbol 0
  assign sym0       = (length == '0) ? load_sym : sym_buf[0];
  assign last       = (LW'(idx) == run_len - LW'(1));

  assign A        = ab[1];
  assign B        = ab[0];
  assign busy     = (state == RUN);
  assign expect_O = (mstate == M2);

  always_comb begin
    state_nx   = state;
    length_nx  = length;
    run_len_nx = run_len;
    idx_nx     = idx;
    hcnt_nx    = hcnt;
    hold_nx    = hold_q;
    loop_nx    = loop_q;
    ab_nx      = ab;
    done_nx    = 1'b0;
    match_clr  = 1'b0;
    case (state)
      IDLE: begin
        length_nx = len_after;
        ab_nx     = 2'b00;
        match_clr = clear | start;
        if (start) begin
          if (len_after != '0) begin
            state_nx   = RUN;
            run_len_nx = len_after;
            hold_nx    = hold_cycles;
            loop_nx    = loop;
            idx_nx     = '0;
            hcnt_nx    = hold_cycles;
            ab_nx      = sym0;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_nx = IDLE;
          ab_nx    = 2'b00;
          done_nx  = 1'b1;
        end else if (hcnt != '0) begin
          hcnt_nx = hcnt - HOLD_W'(1);
        end else if (!last) begin
          idx_nx  = idx + IW'(1);
          hcnt_nx = hold_q;
          ab_nx   = sym_buf[idx + IW'(1)];
        end else if (loop_q) begin
          // wrap straight back to symbol 0, no gap cycle
          idx_nx  = '0;
          hcnt_nx = hold_q;
          ab_nx   = sym_buf[0];
        end else begin
          state_nx = IDLE;
          ab_nx    = 2'b00;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Detector model, driven by the registered stimulus
  always_comb begin
    mstate_nx = M0;
    case (mstate)
      M0: if (ab[1]) mstate_nx = M1;
      M1: if (ab[0]) mstate_nx = M2;
      M2: if (ab[1]) mstate_nx = M3;
      M3: if (ab[0]) mstate_nx = M1;
      default: mstate_nx = M0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      length      <= '0;
      run_len     <= '0;
      idx         <= '0;
      hcnt        <= '0;
      hold_q      <= '0;
      loop_q      <= 1'b0;
      ab          <= 2'b00;
      done        <= 1'b0;
      mstate      <= M0;
      match_count <= '0;
    end else begin
      state   <= state_nx;
      length  <= length_nx;
      run_len <= run_len_nx;
      idx     <= idx_nx;
      hcnt    <= hcnt_nx;
      hold_q  <= hold_nx;
      loop_q  <= loop_nx;
      ab      <= ab_nx;
      done    <= done_nx;
      mstate  <= mstate_nx;
      // M2 has no self-loop, so every cycle with next state M2 is a new entry
      if (match_clr)
        match_count <= '0;
      else if (mstate_nx == M2 && match_count != 16'hFFFF)
        match_count <= match_count + 16'd1;
    end
  end

  // Buffer storage; validity is tracked by length alone
  always_ff @(posedge clk) begin
    if (wr_en) sym_buf[length[IW-1:0]] <= load_sym;
  end

endmodule

// File: tb/tb_abro_stim_gen.sv
// tb_abro_stim_gen
//   Directed scenarios with literal expectations, then randomized runs.
//   A behavioural model (pattern queue + cycle offset arithmetic) predicts
//   every output each cycle; a negedge process compares it with the DUT.
module tb_abro_stim_gen;
  localparam int MAX_LEN = 16;
  localparam int HOLD_W  = 4;

  logic              clk = 1'b0, reset_n = 1'b0;
  logic              clear = 1'b0, load_valid = 1'b0, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [1:0]        load_sym = 2'b00;
  logic [HOLD_W-1:0] hold_cycles = '0;
  logic              load_ready, A, B, busy, done, expect_O;
  logic [15:0]       match_count;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  abro_stim_gen #(.MAX_LEN(MAX_LEN), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load_valid(load_valid),
    .load_sym(load_sym), .load_ready(load_ready), .start(start), .stop(stop),
    .loop(loop), .hold_cycles(hold_cycles), .A(A), .B(B), .busy(busy),
    .done(done), .expect_O(expect_O), .match_count(match_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [1:0] m_pat[$];
  bit m_run = 0, r_loop = 0;
  int r_len = 0, r_hold = 0, r_t = 0;
  bit e_a = 0, e_b = 0, e_busy = 0, e_done = 0, e_ready = 1;
  int e_det = 0, e_cnt = 0;

  // progress of the detector through A,B,A,B (state 2 = detection)
  function automatic int det_next(int s, bit a, bit b);
    case (s)
      0:       return a ? 1 : 0;
      1:       return b ? 2 : 0;
      2:       return a ? 3 : 0;
      default: return b ? 1 : 0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pat.delete();
      m_run = 0; e_a = 0; e_b = 0; e_done = 0; e_det = 0; e_cnt = 0;
    end else begin
      int nd, pos;
      nd = det_next(e_det, e_a, e_b);
      if (nd == 2 && e_cnt < 65535) e_cnt++;
      e_det  = nd;
      e_done = 0;
      if (!m_run) begin
        if (clear) m_pat.delete();
        else if (load_valid && m_pat.size() < MAX_LEN) m_pat.push_back(load_sym);
        if (clear || start) e_cnt = 0;
        if (start) begin
          if (m_pat.size() > 0) begin
            m_run = 1; r_len = m_pat.size(); r_hold = int'(hold_cycles);
            r_loop = loop; r_t = 0; {e_a, e_b} = m_pat[0];
          end else begin
            e_done = 1;
          end
        end
      end else begin
        r_t++;
        pos = r_t / (r_hold + 1);
        if (stop || (pos >= r_len && !r_loop)) begin
          m_run = 0; e_a = 0; e_b = 0; e_done = 1;
        end else begin
          {e_a, e_b} = m_pat[pos % r_len];
        end
      end
    end
    e_busy  = m_run;
    e_ready = !m_run && (m_pat.size() < MAX_LEN);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic [21:0] act, exp;
      act = {A, B, busy, done, expect_O, load_ready, match_count};
      exp = {e_a, e_b, e_busy, e_done, (e_det == 2), e_ready, 16'(e_cnt)};
      n_chk++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL cycle_model @%0t: got {A,B,busy,done,exp,rdy,cnt}=%b expected %b", $time, act, exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] s);
    load_valid = 1'b1; load_sym = s;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic clr();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, hi;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {A, B, busy, done, expect_O}, 0);
    chk("reset_ready", load_ready, 1);
    chk("reset_count", match_count, 0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // two symbols, hold 0
    clr(); load(2'b10); load(2'b01);
    start = 1'b1; tick(); start = 1'b0;
    chk("two_t1", {A, B, busy}, 3'b101);
    tick();
    chk("two_t2", {A, B, busy}, 3'b011);
    tick();
    chk("two_t3", {A, B, busy, done, expect_O}, 5'b00011);
    chk("two_match", match_count, 1);
    tick();
    chk("two_done_once", done, 0);

    // six symbols: detector walks M1,M2,M3,M1,M0,M0
    clr();
    for (int i = 0; i < 6; i++) load((i % 2 == 0) ? 2'b10 : 2'b01);
    start = 1'b1; tick(); start = 1'b0;
    hi = 0;
    for (int k = 1; k <= 7; k++) begin
      hi += int'(expect_O);
      if (k == 6) chk("six_no_early_done", done, 0);
      if (k < 7) tick();
    end
    chk("six_done_t7", done, 1);
    chk("six_expect_once", hi, 1);
    chk("six_match", match_count, 1);

    // hold 2: A for three cycles then B for three
    clr(); load(2'b10); load(2'b01);
    hold_cycles = 2; start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      chk("hold2_ab", {A, B}, (k <= 3) ? 2'b10 : (k <= 6) ? 2'b01 : 2'b00);
      if (k < 7) tick();
    end
    chk("hold2_done_t7", done, 1);
    chk("hold2_match", match_count, 1);
    hold_cycles = 0;

    // fill to capacity, overflow dropped, then clear
    clr();
    for (int i = 0; i < MAX_LEN; i++) begin
      chk("fill_ready", load_ready, 1);
      load(2'($urandom));
    end
    chk("full_ready_low", load_ready, 0);
    load(2'b11);
    chk("full_still_low", load_ready, 0);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (busy && n < 40) begin tick(); n++; end
    chk("full_run_cycles", n, MAX_LEN);
    chk("full_done", done, 1);
    clr();
    chk("clear_ready", load_ready, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("empty_start_done", {busy, done, A, B}, 4'b0100);
    tick();
    chk("empty_done_once", done, 0);

    // loop with stop: alternating A,B walks the detector with period 6
    // (M1,M2,M3,M1,M0,M0), so M2 is entered at t+2 and t+8 only
    clr(); load(2'b10); load(2'b01);
    loop = 1'b1; start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      chk("loop_ab", {A, B, busy}, (k % 2 == 1) ? 3'b101 : 3'b011);
      if (k == 10) stop = 1'b1;
      tick();
    end
    stop = 1'b0; loop = 1'b0;
    chk("loop_stop", {A, B, busy, done}, 4'b0001);
    chk("loop_match", match_count, 2);
    tick();
    chk("loop_single_done", done, 0);

    // stop coinciding with the natural end gives one done
    clr(); load(2'b10);
    start = 1'b1; tick(); start = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_end_done", {busy, done}, 2'b01);
    tick();
    chk("stop_end_once", done, 0);

    // asynchronous reset mid loop run
    clr(); load(2'b10); load(2'b01);
    loop = 1'b1; start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    chk("pre_reset_count", match_count, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {A, B, busy, done, expect_O}, 0);
    chk("rst_mid_ready", load_ready, 1);
    chk("rst_mid_count", match_count, 0);
    loop = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    chk("rst_empty_done", {busy, done, A, B}, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_no_activity", {A, B, busy, done}, 0);
    end

    // randomized runs
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) clr();
      repeat ($urandom_range(0, 6)) begin
        load_valid = ($urandom_range(0, 3) != 0);
        load_sym   = 2'($urandom);
        tick();
      end
      load_valid  = 1'($urandom_range(0, 1));
      load_sym    = 2'($urandom);
      hold_cycles = ($urandom_range(0, 9) == 0) ? HOLD_W'($urandom) : HOLD_W'($urandom_range(0, 3));
      loop        = ($urandom_range(0, 2) == 0);
      start = 1'b1; tick(); start = 1'b0; load_valid = 1'b0;
      n = 0;
      while (busy && n < 400) begin
        load_valid = ($urandom_range(0, 3) == 0);
        load_sym   = 2'($urandom);
        clear      = ($urandom_range(0, 15) == 0);
        start      = ($urandom_range(0, 15) == 0);
        stop       = (n > 350) || ($urandom_range(0, loop ? 7 : 40) == 0);
        tick();
        n++;
      end
      {load_valid, clear, start, stop} = '0;
      chk("run_terminates", busy, 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
